// File: rtl/fp_cvt_arb.sv
// Round-robin shared controller for the int-to-float converter (fcvt.s.w).
// Two requesters feed a 2-stage valid/ready pipeline; results carry NX, tag and source.
module fp_cvt_arb #(
  parameter int unsigned TAG_W = 5,
  parameter int unsigned CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [31:0]      req0_data,
  input  logic [TAG_W-1:0] req0_tag,
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [31:0]      req1_data,
  input  logic [TAG_W-1:0] req1_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [31:0]      out_data,
  output logic [4:0]       out_flags,
  output logic [TAG_W-1:0] out_tag,
  output logic             out_src,
  output logic [CNT_W-1:0] conv_cnt
);

  // Signed int32 to IEEE single, round-to-nearest-even; returns {nx, result}.
  function automatic logic [32:0] fp_cvt(input logic [31:0] op);
    logic        sign;
    logic [31:0] mag;
    logic [31:0] norm;
    logic [4:0]  lead;
    logic        rnd;
    logic [23:0] frac;
    logic [7:0]  expo;
    sign = op[31];
    mag  = sign ? (~op + 32'd1) : op;
    lead = '0;
    for (int i = 0; i < 32; i++) begin
      if (mag[i]) lead = 5'(i);
    end
    norm = mag << (5'd31 - lead);
    // Guard bit set and either sticky bits or an odd LSB means round up.
    rnd  = norm[7] & ((|norm[6:0]) | norm[8]);
    frac = {1'b0, norm[30:8]} + 24'(rnd);
    expo = 8'd127 + {3'd0, lead} + {7'd0, frac[23]};
    if (!norm[31]) return 33'd0;
    return {|norm[7:0], sign, expo, frac[22:0]};
  endfunction

  logic             s1_v, s2_v, rr;
  logic [31:0]      s1_data;
  logic [TAG_W-1:0] s1_tag;
  logic             s1_src;
  logic             s1_can_load, s2_can_load;
  logic             gnt0, gnt1, acc, acc_src;
  logic [32:0]      cvt;

  always_comb begin
    s2_can_load = !s2_v | out_ready;
    s1_can_load = !s1_v | s2_can_load;
    gnt0        = req0_valid & (!req1_valid | !rr);
    gnt1        = req1_valid & (!req0_valid | rr);
    req0_ready  = gnt0 & s1_can_load & !flush;
    req1_ready  = gnt1 & s1_can_load & !flush;
    acc_src     = req1_valid & req1_ready;
    acc         = (req0_valid & req0_ready) | acc_src;
    cvt         = fp_cvt(s1_data);
    out_valid   = s2_v;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_v    <= 1'b0;
      s1_data <= '0;
      s1_tag  <= '0;
      s1_src  <= 1'b0;
      rr      <= 1'b0;
    end else if (flush) begin
      s1_v <= 1'b0;
    end else if (s1_can_load) begin
      s1_v <= acc;
      if (acc) begin
        s1_data <= acc_src ? req1_data : req0_data;
        s1_tag  <= acc_src ? req1_tag : req0_tag;
        s1_src  <= acc_src;
        rr      <= ~acc_src;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s2_v      <= 1'b0;
      out_data  <= '0;
      out_flags <= '0;
      out_tag   <= '0;
      out_src   <= 1'b0;
    end else if (flush) begin
      s2_v <= 1'b0;
    end else if (s2_can_load) begin
      s2_v <= s1_v;
      if (s1_v) begin
        out_data  <= cvt[31:0];
        out_flags <= {4'b0000, cvt[32]};
        out_tag   <= s1_tag;
        out_src   <= s1_src;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      conv_cnt <= '0;
    end else if (!flush && s2_v && out_ready) begin
      conv_cnt <= conv_cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_fp_cvt_arb.sv
// Randomized bench for fp_cvt_arb against an arithmetic conversion model and a result queue.
module tb_fp_cvt_arb;
  localparam int TAG_W = 5;
  localparam int CNT_W = 4;

  logic             clk = 1'b0;
  logic             rst, flush;
  logic             req0_valid, req0_ready, req1_valid, req1_ready;
  logic [31:0]      req0_data, req1_data;
  logic [TAG_W-1:0] req0_tag, req1_tag;
  logic             out_valid, out_ready, out_src;
  logic [31:0]      out_data;
  logic [4:0]       out_flags;
  logic [TAG_W-1:0] out_tag;
  logic [CNT_W-1:0] conv_cnt;

  fp_cvt_arb #(.TAG_W(TAG_W), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_data(req0_data), .req0_tag(req0_tag),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_data(req1_data), .req1_tag(req1_tag),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_flags(out_flags),
    .out_tag(out_tag), .out_src(out_src), .conv_cnt(conv_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0]      bits;
    logic             nx;
    logic [TAG_W-1:0] tag;
    logic             src;
    int               cyc;
  } item_t;

  item_t sb[$];
  int    now, m_cnt, checks, errors;
  logic  m_rr, last_acc0, last_acc1;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, obs, exp, now);
    end
  endtask

  // Exact value of the integer, quantized to a 24-bit significand with ties to even.
  function automatic logic [32:0] ref_cvt(input logic [31:0] x);
    longint sx, m, q, k, rem, frac;
    int     e;
    logic   s;
    sx = longint'($signed(x));
    s  = (sx < 0);
    m  = s ? -sx : sx;
    if (m == 0) return 33'd0;
    e = 0;
    while ((64'sd1 << (e + 1)) <= m) e++;
    q   = (e > 23) ? (64'sd1 << (e - 23)) : 64'sd1;
    k   = m / q;
    rem = m % q;
    if ((2 * rem > q) || ((2 * rem == q) && k[0])) k++;
    if (k == (64'sd1 << 24)) begin
      k = 64'sd1 << 23;
      e++;
    end
    frac = ((e > 23) ? k : (m << (23 - e))) - (64'sd1 << 23);
    return {rem != 0, s, 8'(127 + e), frac[22:0]};
  endfunction

  function automatic logic [31:0] rnd_op();
    logic [31:0] v;
    case ($urandom_range(0, 3))
      0:       v = $urandom;
      1:       v = $urandom_range(0, 255);
      2:       v = $urandom >> $urandom_range(0, 31);
      default: v = -$urandom_range(0, 300);
    endcase
    return v;
  endfunction

  // One clock cycle: drive, check against the model, then advance the model past the edge.
  task automatic step(input logic v0, input logic [31:0] d0, input logic [TAG_W-1:0] t0,
                      input logic v1, input logic [31:0] d1, input logic [TAG_W-1:0] t1,
                      input logic ordy, input logic fl);
    logic        g0, g1, room, er0, er1, ev;
    logic [32:0] r;
    item_t       it;
    @(negedge clk);
    req0_valid = v0; req0_data = d0; req0_tag = t0;
    req1_valid = v1; req1_data = d1; req1_tag = t1;
    out_ready = ordy; flush = fl;
    #1;
    g0   = v0 & (!v1 | !m_rr);
    g1   = v1 & (!v0 | m_rr);
    room = (sb.size() < 2) | ordy;
    er0  = g0 & room & !fl;
    er1  = g1 & room & !fl;
    check("req0_ready", 64'(req0_ready), 64'(er0));
    check("req1_ready", 64'(req1_ready), 64'(er1));
    ev = (sb.size() > 0) && (sb[0].cyc + 2 <= now);
    check("out_valid", 64'(out_valid), 64'(ev));
    if (ev) begin
      check("out_data", 64'(out_data), 64'(sb[0].bits));
      check("out_flags", 64'(out_flags), 64'({4'b0000, sb[0].nx}));
      check("out_tag", 64'(out_tag), 64'(sb[0].tag));
      check("out_src", 64'(out_src), 64'(sb[0].src));
    end
    check("conv_cnt", 64'(conv_cnt), 64'(m_cnt % (1 << CNT_W)));
    last_acc0 = er0;
    last_acc1 = er1;
    if (fl) begin
      sb.delete();
    end else begin
      if (ev && ordy) begin
        void'(sb.pop_front());
        m_cnt++;
      end
      if (er0 || er1) begin
        r       = ref_cvt(er1 ? d1 : d0);
        it.bits = r[31:0];
        it.nx   = r[32];
        it.tag  = er1 ? t1 : t0;
        it.src  = er1;
        it.cyc  = now;
        sb.push_back(it);
        m_rr    = er0;
      end
    end
    now++;
  endtask

  task automatic idle(input logic ordy);
    step(1'b0, 32'd0, '0, 1'b0, 32'd0, '0, ordy, 1'b0);
  endtask

  // Pulse reset between clock edges and verify outputs clear without waiting for a clock.
  task automatic pulse_reset();
    @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_out_data", 64'(out_data), 64'd0);
    check("rst_out_flags", 64'(out_flags), 64'd0);
    check("rst_out_tag", 64'(out_tag), 64'd0);
    check("rst_out_src", 64'(out_src), 64'd0);
    check("rst_conv_cnt", 64'(conv_cnt), 64'd0);
    req0_valid = 1'b0; req1_valid = 1'b0; flush = 1'b0; out_ready = 1'b1;
    #1;
    rst = 1'b0;
    sb.delete();
    m_rr  = 1'b0;
    m_cnt = 0;
  endtask

  task automatic run_single(input logic [31:0] d, input logic [TAG_W-1:0] t,
                            input logic [31:0] eb, input logic [4:0] ef);
    step(1'b1, d, t, 1'b0, 32'd0, '0, 1'b1, 1'b0);
    idle(1'b1);
    idle(1'b1);
    check("single_valid", 64'(out_valid), 64'd1);
    check("single_data", 64'(out_data), 64'(eb));
    check("single_flags", 64'(out_flags), 64'(ef));
    check("single_tag", 64'(out_tag), 64'(t));
  endtask

  initial begin
    int idx;
    checks = 0; errors = 0; now = 0; m_cnt = 0; m_rr = 1'b0;
    rst = 1'b1; flush = 1'b0; out_ready = 1'b1;
    req0_valid = 1'b0; req0_data = '0; req0_tag = '0;
    req1_valid = 1'b0; req1_data = '0; req1_tag = '0;
    #3;
    check("init_out_valid", 64'(out_valid), 64'd0);
    check("init_conv_cnt", 64'(conv_cnt), 64'd0);
    #4 rst = 1'b0;

    // Single conversion and value sweep.
    run_single(32'h0000_0001, 5'd3, 32'h3F80_0000, 5'b00000);
    check("single_src", 64'(out_src), 64'd0);
    idle(1'b1);
    check("single_cnt", 64'(conv_cnt), 64'd1);
    run_single(32'hFFFF_FFFF, 5'd4, 32'hBF80_0000, 5'b00000);
    run_single(32'h0100_0001, 5'd5, 32'h4B80_0000, 5'b00001);
    run_single(32'h8000_0000, 5'd6, 32'hCF00_0000, 5'b00000);
    run_single(32'h0000_0000, 5'd7, 32'h0000_0000, 5'b00000);
    run_single(32'h7FFF_FFFF, 5'd8, 32'h4F00_0000, 5'b00001);

    // Round-robin with both requesters continuously valid.
    pulse_reset();
    for (int i = 0; i < 10; i++) begin
      step(1'b1, rnd_op(), 5'(i), 1'b1, rnd_op(), 5'(16 + i), 1'b1, 1'b0);
      check("rr_grant1", 64'(last_acc1), 64'(i % 2));
    end
    repeat (3) idle(1'b1);

    // Backpressure: six operands from req1 while the consumer stalls for five cycles.
    idx = 0;
    for (int c = 0; c < 16; c++) begin
      step(1'b0, 32'd0, '0, idx < 6, 32'h0000_1000 + 32'(idx), 5'(idx), c >= 5, 1'b0);
      if (last_acc1) idx++;
    end
    check("bp_all_accepted", 64'(idx), 64'd6);
    repeat (3) idle(1'b1);

    // Flush with both stages full.
    step(1'b1, 32'd11, 5'd1, 1'b0, 32'd0, '0, 1'b0, 1'b0);
    step(1'b1, 32'd12, 5'd2, 1'b0, 32'd0, '0, 1'b0, 1'b0);
    step(1'b1, 32'd13, 5'd3, 1'b1, 32'd14, 5'd4, 1'b0, 1'b1);
    idle(1'b1);
    check("flush_out_valid", 64'(out_valid), 64'd0);
    run_single(32'd100, 5'd9, 32'h42C8_0000, 5'b00000);

    // Random traffic, interrupted by an asynchronous reset.
    for (int i = 0; i < 40; i++) begin
      step($urandom_range(0, 1), rnd_op(), 5'($urandom), $urandom_range(0, 1), rnd_op(),
           5'($urandom), $urandom_range(0, 3) != 0, 1'b0);
    end
    pulse_reset();

    // Seventeen completions wrap the 4-bit counter to one.
    for (int i = 0; i < 17; i++) step(1'b1, 32'(i), 5'(i), 1'b0, 32'd0, '0, 1'b1, 1'b0);
    repeat (3) idle(1'b1);
    check("cnt_wrap", 64'(conv_cnt), 64'd1);

    for (int i = 0; i < 400; i++) begin
      step($urandom_range(0, 1), rnd_op(), 5'($urandom), $urandom_range(0, 1), rnd_op(),
           5'($urandom), $urandom_range(0, 9) < 7, $urandom_range(0, 31) == 0);
    end
    repeat (4) idle(1'b1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
